// File: rtl/gf_arith_pkg.sv
// Shared arithmetic package: FSM state encoding and chunk-geometry helper
// used by the chunked ripple-borrow subtractor.
package gf_arith_pkg;

    // Sequencer state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of chunks in a word and the width of a counter that indexes them.
    typedef struct packed {
        int num_chunks;
        int cnt_width;
    } chunk_cfg_t;

    // Derives chunk count and counter width from the data and chunk widths.
    // The counter is always at least one bit wide so a single-chunk build
    // still has a legal register.
    function automatic chunk_cfg_t chunk_cfg(input int data_width, input int chunk_width);
        chunk_cfg_t cfg;
        cfg.num_chunks = data_width / chunk_width;
        cfg.cnt_width  = (cfg.num_chunks > 1) ? $clog2(cfg.num_chunks) : 1;
        return cfg;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bi, bo is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic diff,
    output logic bo
);

    // A borrow is produced when b exceeds a, or when a equals b and a
    // borrow is already pending from the less-significant bit.
    always_comb begin
        diff = a ^ b ^ bi;
        bo   = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/rbs_subtractor.sv
// Multi-cycle ripple-borrow subtractor. A DATA_WIDTH subtraction is done
// CHUNK_WIDTH bits per enabled cycle, least-significant chunk first, with
// the borrow carried in a register between chunks.
// Optional feature: define RBS_SUBTRACTOR_OVERFLOW_EN to add out_overflow,
// the signed two's-complement overflow flag of the result.
module rbs_subtractor
    import gf_arith_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_sub_a,
    input  logic [DATA_WIDTH-1:0] in_sub_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out_diff_result,
    output logic                  out_borrow
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic                  out_overflow
`endif
);

    // DATA_WIDTH must be a whole multiple of CHUNK_WIDTH; the chunk
    // count below truncates otherwise.
    localparam chunk_cfg_t CFG        = chunk_cfg(DATA_WIDTH, CHUNK_WIDTH);
    localparam int         NUM_CHUNKS = CFG.num_chunks;
    localparam int         CNT_W      = CFG.cnt_width;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  borrow_reg;
    logic [DATA_WIDTH-1:0] a_sh_reg;
    logic [DATA_WIDTH-1:0] b_sh_reg;

    logic [CHUNK_WIDTH-1:0] chunk_diff;
    logic [CHUNK_WIDTH:0]   borrow_chain;
    logic [DATA_WIDTH-1:0]  diff_next;

`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
    logic a_sign_reg;
    logic b_sign_reg;
    logic overflow_next;
`endif

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

    // Per-bit ripple chain for the current chunk. The operand shift
    // registers always present the chunk being processed in their low bits.
    assign borrow_chain[0] = borrow_reg;

    generate
        for (genvar gi = 0; gi < CHUNK_WIDTH; gi++) begin : g_bit
            full_subtractor u_fs (
                .a    (a_sh_reg[gi]),
                .b    (b_sh_reg[gi]),
                .bi   (borrow_chain[gi]),
                .diff (chunk_diff[gi]),
                .bo   (borrow_chain[gi+1])
            );
        end
    endgenerate

    // Partial-result accumulator. Each new chunk enters at the top and the
    // older chunks slide down, so after the last chunk the concatenation of
    // the new chunk with the accumulator is the full result, LSB at bit 0.
    generate
        if (NUM_CHUNKS > 1) begin : g_multi
            logic [DATA_WIDTH-CHUNK_WIDTH-1:0] diff_sh_reg;

            assign diff_next = {chunk_diff, diff_sh_reg};

            // Shift each computed chunk into the partial result while running.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff_sh_reg <= '0;
                end else if (enable && (state_reg == ST_RUN)) begin
                    diff_sh_reg <= diff_next[DATA_WIDTH-1:CHUNK_WIDTH];
                end
            end
        end else begin : g_single
            assign diff_next = chunk_diff;
        end
    endgenerate

`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
    // Signed overflow: operands of opposite sign and a result whose sign
    // disagrees with the minuend.
    assign overflow_next = (a_sign_reg ^ b_sign_reg) & (diff_next[DATA_WIDTH-1] ^ a_sign_reg);
`endif

    // Sequencer: accept, step one chunk per enabled cycle, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            borrow_reg      <= 1'b0;
            a_sh_reg        <= '0;
            b_sh_reg        <= '0;
            out_diff_result <= '0;
            out_borrow      <= 1'b0;
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
            a_sign_reg      <= 1'b0;
            b_sign_reg      <= 1'b0;
            out_overflow    <= 1'b0;
`endif
        end else if (enable) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg   <= in_sub_a;
                        b_sh_reg   <= in_sub_b;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_RUN;
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
                        a_sign_reg <= in_sub_a[DATA_WIDTH-1];
                        b_sign_reg <= in_sub_b[DATA_WIDTH-1];
`endif
                    end
                end

                ST_RUN: begin
                    a_sh_reg   <= a_sh_reg >> CHUNK_WIDTH;
                    b_sh_reg   <= b_sh_reg >> CHUNK_WIDTH;
                    borrow_reg <= borrow_chain[CHUNK_WIDTH];
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CHUNK) begin
                        out_diff_result <= diff_next;
                        out_borrow      <= borrow_chain[CHUNK_WIDTH];
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
                        out_overflow    <= overflow_next;
`endif
                        state_reg       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbs_subtractor.sv
// Scoreboard bench for rbs_subtractor (DATA_WIDTH=32, CHUNK_WIDTH=8).
// Define RBS_SUBTRACTOR_OVERFLOW_EN to also check out_overflow.
module tb_rbs_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in_sub_a = '0;
    logic [31:0] in_sub_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] out_diff_result;
    logic        out_borrow;
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
    logic        out_overflow;
`endif

    rbs_subtractor #(
        .DATA_WIDTH  (32),
        .CHUNK_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .start           (start),
        .in_sub_a        (in_sub_a),
        .in_sub_b        (in_sub_b),
        .busy            (busy),
        .done            (done),
        .out_diff_result (out_diff_result),
        .out_borrow      (out_borrow)
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
        ,
        .out_overflow    (out_overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   done_pulses = 0;
    int   ops_pushed = 0;
    bit   done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard pop per done pulse (done may be held by enable=0).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!done) begin
                done_seen = 1'b0;
            end else if (!done_seen) begin
                done_seen = 1'b1;
                done_pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("op a=0x%08h b=0x%08h -> diff=0x%08h borrow=%0d (expect 0x%08h/%0d)",
                             e.a, e.b, out_diff_result, out_borrow, e.diff, e.borrow);
                    check("diff", out_diff_result, e.diff);
                    check("borrow", 32'(out_borrow), 32'(e.borrow));
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
                    check("overflow", 32'(out_overflow), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Present operands with start for one edge; optionally record expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                         input logic bo, input logic ov, input bit push, input bit hold);
        exp_t e;
        e.a = a; e.b = b; e.diff = d; e.borrow = bo; e.ovf = ov;
        if (push) begin
            exp_q.push_back(e);
            ops_pushed++;
        end
        in_sub_a = a;
        in_sub_b = b;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        // Scramble the inputs: the operation must use the latched operands.
        in_sub_a = $urandom;
        in_sub_b = $urandom;
    endtask

    // Count enabled-or-not edges until done is seen; bounded.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                          input logic bo, input logic ov);
        int n;
        issue(a, b, d, bo, ov, 1'b1, 1'b0);
        wait_done(n);
        check("latency", 32'(n), 32'd4);
        check("busy_in_done", 32'(busy), 32'd1);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int pulses_before;

        // Reset state.
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", out_diff_result, 32'd0);
        check("rst_borrow", 32'(out_borrow), 32'd0);
`ifdef RBS_SUBTRACTOR_OVERFLOW_EN
        check("rst_overflow", 32'(out_overflow), 32'd0);
`endif
        #20 rst_n = 1'b1;
        tick();

        // Basic, full-width borrow ripple, equal operands, mixed pattern.
        run_op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1, 1'b1);

        // Borrow across chunk boundaries with start held high throughout.
        issue(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_done(n);
        check("latency_start_held", 32'(n), 32'd4);
        tick();
        check("start_ignored_in_done", 32'(busy), 32'd0);
        check("single_done_pulse", 32'(done), 32'd0);
        start = 1'b0;
        tick();
        check("no_restart_without_start", 32'(busy), 32'd0);
        check("result_held", out_diff_result, 32'h0000_FFFF);

        // Stall for three cycles mid-run; done is delayed by three.
        issue(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_no_done", 32'(done), 32'd0);
        end
        enable = 1'b1;
        wait_done(n);
        check("latency_stalled", 32'(n + 4), 32'd7);
        // done held while disabled.
        enable = 1'b0;
        tick();
        check("done_held_1", 32'(done), 32'd1);
        tick();
        check("done_held_2", 32'(done), 32'd1);
        enable = 1'b1;
        tick();
        check("done_released", 32'(done), 32'd0);

        // Reset in mid-run aborts with no done pulse.
        pulses_before = done_pulses;
        issue(32'h0000_0007, 32'h0000_0009, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", out_diff_result, 32'd0);
        check("abort_borrow", 32'(out_borrow), 32'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("abort_no_pulse", 32'(done_pulses), 32'(pulses_before));
        run_op(32'h0000_0007, 32'h0000_0009, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // Signed overflow case (diff/borrow checked in every build).
        run_op(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_pulse_count", 32'(done_pulses), 32'(ops_pushed));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
